// File: rtl/shift_op_pipe.sv
// shift_op_pipe: issue/retire pipeline around an external combinational
// right-arithmetic log shifter. SRL, SRA and SLL are folded onto the single
// right-arithmetic datapath by pre/post-processing. One operand register (A)
// feeds the shifter; one output register holds the retired result.
//
// Build option: define SHIFT_ROTATE_EN to implement op 11 as ROR (two passes
// through the shifter via a ROT2 state). Without it, op 11 retires in a
// single pass with out_data = operand and out_err = 1.
module shift_op_pipe #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SHAMT_W = 6,
  parameter int unsigned TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  // request side
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  // shifter instance
  output logic [DATA_W-1:0]  sh_in,
  output logic [SHAMT_W-1:0] sh_amt,
  input  logic [DATA_W-1:0]  sh_result,
  // result side
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  // The shift amount must address every bit of the operand exactly.
  if (SHAMT_W != $clog2(DATA_W)) begin : gen_param_check
    $error("shift_op_pipe: SHAMT_W must equal log2(DATA_W)");
  end

  localparam logic [1:0] OpSrl = 2'b00;
  localparam logic [1:0] OpSra = 2'b01;
  localparam logic [1:0] OpSll = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

`ifdef SHIFT_ROTATE_EN
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StRot2 = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StExec = 1'b1
  } state_e;
`endif

  state_e              state_q;

  // Operand register A
  logic [1:0]          a_op_q;
  logic [DATA_W-1:0]   a_data_q;
  logic [SHAMT_W-1:0]  a_shamt_q;
  logic [TAG_W-1:0]    a_tag_q;

  // Output register
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [TAG_W-1:0]    out_tag_q;
  logic                out_err_q;

`ifdef SHIFT_ROTATE_EN
  // First-pass (logical right) half of a rotate
  logic [DATA_W-1:0]   partial_q;
  logic                ror_split;
`endif

  logic                a_valid;
  logic                a_done;
  logic                out_free;
  logic                out_wr;
  logic                accept;
  logic [DATA_W-1:0]   pass_masked;
  logic [DATA_W-1:0]   result;
  logic                result_err;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  assign a_valid = (state_q != StIdle);

`ifdef SHIFT_ROTATE_EN
  // A non-zero rotate needs the second pass; a zero rotate is just the operand.
  assign ror_split = (state_q == StExec) && (a_op_q == OpRor) && (a_shamt_q != '0);
`endif

  // Shifter operand selection; bit-reversal turns a left shift into a right one.
  always_comb begin
    sh_in  = '0;
    sh_amt = '0;
    case (state_q)
      StExec: begin
        sh_amt = a_shamt_q;
        sh_in  = (a_op_q == OpSll) ? bit_rev(a_data_q) : a_data_q;
      end
`ifdef SHIFT_ROTATE_EN
      StRot2: begin
        // Left shift by (DATA_W - s) mod DATA_W; modulo falls out of the width.
        sh_in  = bit_rev(a_data_q);
        sh_amt = SHAMT_W'(0) - a_shamt_q;
      end
`endif
      default: ;
    endcase
  end

  // Clearing the top sh_amt bits undoes the sign fill of the arithmetic shifter.
  assign pass_masked = sh_result & ({DATA_W{1'b1}} >> sh_amt);

  // Post-processing of the shifter output and completion decision for A.
  always_comb begin
    result     = '0;
    result_err = 1'b0;
    a_done     = 1'b0;
    case (state_q)
      StExec: begin
        a_done = 1'b1;
        case (a_op_q)
          OpSra: result = sh_result;
          OpSrl: result = pass_masked;
          OpSll: result = bit_rev(pass_masked);
          OpRor: begin
            result = a_data_q;
`ifdef SHIFT_ROTATE_EN
            a_done = !ror_split;
`else
            result_err = 1'b1;
`endif
          end
          default: ;
        endcase
      end
`ifdef SHIFT_ROTATE_EN
      StRot2: begin
        a_done = 1'b1;
        result = partial_q | bit_rev(pass_masked);
      end
`endif
      default: ;
    endcase
  end

  assign out_free = !out_valid_q || out_ready;
  assign out_wr   = a_valid && a_done && out_free;
  // A frees up in the same cycle it retires, so back-to-back issue is lossless.
  assign in_ready = !a_valid || (a_done && out_free);
  assign accept   = in_valid && in_ready;

  // FSM, operand register A and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_op_q      <= '0;
      a_data_q    <= '0;
      a_shamt_q   <= '0;
      a_tag_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      partial_q   <= '0;
`endif
    end else begin
      // Output register: reload on retire, otherwise drain on handshake.
      if (out_wr) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
        out_tag_q   <= a_tag_q;
        out_err_q   <= result_err;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        a_op_q    <= in_op;
        a_data_q  <= in_data;
        a_shamt_q <= in_shamt;
        a_tag_q   <= in_tag;
      end

      // accept while A is busy implies A retires this cycle.
      if (accept) begin
        state_q <= StExec;
      end else if (out_wr) begin
        state_q <= StIdle;
`ifdef SHIFT_ROTATE_EN
      end else if (ror_split) begin
        state_q   <= StRot2;
        partial_q <= pass_masked;
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_shift_op_pipe.sv
// Testbench for shift_op_pipe: models the external shifter, drives directed and
// random requests, and checks results through an expected-response queue.
module tb_shift_op_pipe;

  localparam int unsigned DW = 64;
  localparam int unsigned SW = 6;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [TW-1:0] in_tag = '0;
  logic [DW-1:0] sh_in;
  logic [SW-1:0] sh_amt;
  logic [DW-1:0] sh_result;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_err;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic rand_done = 1'b0;

  shift_op_pipe #(.DATA_W(DW), .SHAMT_W(SW), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .sh_in     (sh_in),
    .sh_amt    (sh_amt),
    .sh_result (sh_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  // Combinational right-arithmetic shifter the DUT is wrapped around.
  assign sh_result = $signed(sh_in) >>> sh_amt;

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    end
  endtask

  // Reference semantics of each op, straight from the arithmetic definitions.
  function automatic void model(input logic [1:0] op, input logic [63:0] d,
                                input logic [5:0] s, output logic [63:0] r,
                                output logic e);
    e = 1'b0;
    case (op)
      2'b00: r = d >> s;
      2'b01: r = $signed(d) >>> s;
      2'b10: r = d << s;
      default: begin
`ifdef SHIFT_ROTATE_EN
        r = (s == 0) ? d : ((d >> s) | (d << (64 - int'(s))));
`else
        r = d;
        e = 1'b1;
`endif
      end
    endcase
  endfunction

  // Present a request until accepted; push its expected response on accept.
  // Called and returns at posedge+1.
  task automatic send_exp(input logic [1:0] op, input logic [63:0] d, input logic [5:0] s,
                          input logic [3:0] t, input logic [63:0] ed, input logic ee);
    exp_t x;
    logic accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
    for (int c = 0; c < 60 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        x.data = ed;
        x.tag  = t;
        x.err  = ee;
        exp_q.push_back(x);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: request tag %0d not accepted, in_ready=%b", t, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [63:0] d, input logic [5:0] s,
                      input logic [3:0] t);
    logic [63:0] r;
    logic e;
    model(op, d, s, r, e);
    send_exp(op, d, s, t, r, e);
  endtask

  // Called right after an accept on an empty pipe: out_valid low for lat
  // negedges, then high.
  task automatic check_latency(input int lat, input string name);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check({name, "_early"}, out_valid, 1'b0);
    end
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every output handshake, checks hold-stable under stall.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [TW-1:0] prev_tag;
    exp_t          x;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_tag   = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_data", out_data, prev_data);
          check("stall_tag", out_tag, prev_tag);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got data 0x%h tag %0d, required none", out_data,
                     out_tag);
          end else begin
            x = exp_q.pop_front();
            check("out_data", out_data, x.data);
            check("out_tag", out_tag, x.tag);
            check("out_err", out_err, x.err);
          end
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_data  = out_data;
        prev_tag   = out_tag;
      end
    end
  end

  task automatic drain(input string name);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    // Reset with a pending request.
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_tag", out_tag, 4'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with single-pass latency.
    send_exp(2'b01, 64'h8000_0000_0000_0010, 6'd4, 4'd3, 64'hF800_0000_0000_0001, 1'b0);
    check_latency(1, "sra_lat");
    send_exp(2'b00, 64'h8000_0000_0000_0010, 6'd4, 4'd5, 64'h0800_0000_0000_0001, 1'b0);
    check_latency(1, "srl_lat");
    send_exp(2'b00, 64'h8000_0000_0000_0010, 6'd0, 4'd6, 64'h8000_0000_0000_0010, 1'b0);
    check_latency(1, "srl0_lat");
    send_exp(2'b10, 64'h0000_0000_0000_0001, 6'd63, 4'd7, 64'h8000_0000_0000_0000, 1'b0);
    check_latency(1, "sll63_lat");
    send_exp(2'b10, 64'h8000_0000_0000_0001, 6'd1, 4'd8, 64'h0000_0000_0000_0002, 1'b0);
    check_latency(1, "sll1_lat");
`ifdef SHIFT_ROTATE_EN
    send_exp(2'b11, 64'h0000_0000_0000_00F1, 6'd4, 4'd9, 64'h1000_0000_0000_000F, 1'b0);
    check_latency(2, "ror_lat");
    send_exp(2'b11, 64'h0123_4567_89AB_CDEF, 6'd0, 4'd10, 64'h0123_4567_89AB_CDEF, 1'b0);
    check_latency(1, "ror0_lat");
`else
    send_exp(2'b11, 64'h0000_0000_0000_00F1, 6'd4, 4'd9, 64'h0000_0000_0000_00F1, 1'b1);
    check_latency(1, "op11_lat");
`endif
    drain("directed_drain");

    // Backpressure: 4 back-to-back ops while the consumer stalls 3 cycles.
    out_ready = 1'b0;
    fork
      begin
        send(2'b01, 64'hF000_0000_0000_1234, 6'd8, 4'd1);
        send(2'b00, 64'hF000_0000_0000_1234, 6'd12, 4'd2);
        send(2'b10, 64'h0000_0000_00AB_CDEF, 6'd20, 4'd3);
        send(2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 4'd4);
      end
      begin
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
          @(negedge clk);
          seen = (out_valid === 1'b1);
        end
        check("bp_first_valid", seen, 1'b1);
        check("bp_in_ready0", in_ready, 1'b0);
        for (int k = 1; k < 3; k++) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset mid-operation discards in-flight ops.
    out_ready = 1'b0;
    send(2'b00, 64'h1111_2222_3333_4444, 6'd3, 4'd11);
    send(2'b10, 64'h5555_6666_7777_8888, 6'd5, 4'd12);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic with random consumer backpressure.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [1:0]  op;
          logic [63:0] d;
          logic [5:0]  s;
          op = 2'($urandom_range(0, 3));
          d  = {$urandom, $urandom};
          case ($urandom_range(0, 7))
            0: s = 6'd0;
            1: s = 6'd63;
            default: s = 6'($urandom_range(0, 63));
          endcase
          send(op, d, s, 4'($urandom_range(0, 15)));
          for (int g = int'($urandom_range(0, 3)); g > 1; g--) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_op_pipe.md
Name: shift_op_pipe

Overview:
- Issue/retire pipeline wrapped around the 64-bit combinational right-arithmetic log shifter.
- Accepts shift operations over a valid/ready handshake and registers the operands.
- Pre-processes operands so SRL, SRA and SLL all run on the single right-arithmetic datapath, then post-processes the result.
- Returns the result with a tag over a valid/ready handshake. Sits between the ALU operand dispatch and the shifter instance.

Parameters:
- DATA_W, 64, operand/result width; must equal the shifter width.
- SHAMT_W, 6, shift-amount width, log2(DATA_W).
- TAG_W, 4, opaque request tag, returned unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  2  00 SRL, 01 SRA, 10 SLL, 11 ROR/reserved.
- in_data  in  DATA_W  operand.
- in_shamt  in  SHAMT_W  shift amount.
- in_tag  in  TAG_W  request tag.
- sh_in  out  DATA_W  shifter data input.
- sh_amt  out  SHAMT_W  shifter shift_amount.
- sh_result  in  DATA_W  shifter result (combinational, same cycle).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_W  result.
- out_tag  out  TAG_W  tag of result.
- out_err  out  1  op 11 issued with feature compiled out.

Behaviour:
- Reset (rst_n low at a clk edge): FSM=IDLE; out_valid=0; out_data=0; out_tag=0; out_err=0; in_ready=1 in the following cycle. Reset mid-operation discards in-flight ops.
- Operand register A captures op/data/shamt/tag on handshake.
- FSM states and transitions:
  - IDLE -> EXEC on accept.
  - EXEC -> IDLE, or EXEC -> EXEC on back-to-back accept, when the result is written to the output register.
  - EXEC -> ROT2 for ROR (feature only).
  - ROT2 -> IDLE/EXEC on result write.
- Operation mapping, with s = shamt:
  - SRA: sh_in=data, sh_amt=s, result=sh_result.
  - SRL: sh_in=data, sh_amt=s, result=sh_result with the top s bits forced to 0. s=0 leaves the result unmasked.
  - SLL: sh_in=bitrev(data), sh_amt=s, result=bitrev(sh_result with the top s bits forced to 0).
- Output register is written when A is valid, the op completes this cycle, and (!out_valid || out_ready).
- in_ready = !A_valid || (A completes this cycle && (!out_valid || out_ready)). This gives full throughput under continuous out_ready.
- Latency: accept at edge N, out_valid from edge N+1 (single pass).
- Backpressure: out_* hold stable while out_valid && !out_ready. A holds and in_ready=0.
- Simultaneous out handshake and new result: the output register reloads, and out_valid stays 1.
- sh_in/sh_amt are 0 when A is invalid.

Optional Feature:
- Macro SHIFT_ROTATE_EN.
- Defined, op 11 = ROR:
  - EXEC pass: SRL(data,s) is stored in a partial register.
  - ROT2 pass: SLL(data,(DATA_W-s) mod DATA_W); result = partial | pass2.
  - s=0: result=data in a single pass.
  - Latency 2 edges; in_ready=0 during EXEC of a ROR.
  - out_err is always 0.
- Undefined: op 11 completes single-pass with out_data=data, out_err=1. No ROT2 state exists.

Test Plan:
- Reset with in_valid=1 -> out_valid=0, out_data=0 in the cycle after the reset edge; in_ready=1.
- SRA data=0x8000_0000_0000_0010, s=4, tag=3 -> 0xF800_0000_0000_0001, tag 3, one edge after accept.
- SRL same data, s=4 -> 0x0800_0000_0000_0001; then s=0 -> data unchanged.
- SLL data=0x0000_0000_0000_0001, s=63 -> 0x8000_0000_0000_0000; s=1 on 0x8000_0000_0000_0001 -> 0x0000_0000_0000_0002.
- 4 back-to-back ops with out_ready low for 3 cycles -> first result held stable, in_ready=0 while A is full, all 4 results returned in order with correct tags, none lost or duplicated.
- Op 11 data=0x0000_0000_0000_00F1, s=4:
  - With SHIFT_ROTATE_EN -> 0x1000_0000_0000_000F after 2 edges.
  - Without it -> 0x0000_0000_0000_00F1 with out_err=1.
